// File: rtl/memory_stage_lsu_pkg.sv
// memory_stage_lsu_pkg: shared types, funct3 codes and lane helpers for the MEM-stage load/store unit
package memory_stage_lsu_pkg;
  typedef struct packed {
    logic mem_read;
    logic mem_write;
  } control_t;
  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD} mem_size_t;
  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, ACCESS_HI, WAIT_HI, DONE} lsu_state_t;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam int F3_UNS = 2;
  function automatic mem_size_t to_size(input logic [1:0] f);
    return f == F3_B[1:0] ? MEM_BYTE : f == F3_H[1:0] ? MEM_HALF : MEM_WORD;
  endfunction
  function automatic logic [3:0] size_mask(input mem_size_t s);
    return s == MEM_BYTE ? 4'b0001 : s == MEM_HALF ? 4'b0011 : 4'b1111;
  endfunction
  function automatic logic is_misaligned(input mem_size_t s, input logic [1:0] off);
    return (s == MEM_HALF && off[0]) || (s == MEM_WORD && off != 2'd0);
  endfunction
  function automatic logic [31:0] extend(input logic [31:0] lane, input mem_size_t s, input logic uns);
    return s == MEM_BYTE ? {{24{lane[7] & ~uns}}, lane[7:0]} :
           s == MEM_HALF ? {{16{lane[15] & ~uns}}, lane[15:0]} : lane;
  endfunction
endpackage

// File: rtl/memory_stage_lsu_data_memory_be.sv
// data_memory_be: word array with byte-enable writes and a registered read delayed by WAIT_STATES extra stages
module data_memory_be #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] pipe [WAIT_STATES+1];
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    pipe[0] <= mem[addr];
    for (int i = 1; i <= WAIT_STATES; i++) pipe[i] <= pipe[i-1];
  end
  assign rdata = pipe[WAIT_STATES];
endmodule

// File: rtl/memory_stage_lsu.sv
// memory_stage_lsu: MEM-stage load/store unit with byte/half/word access, wait states and stall.
// Define MEM_MISALIGN_SPLIT_EN to split misaligned accesses into two word accesses instead of rejecting them.
module memory_stage_lsu
  import memory_stage_lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] mem_data_in,
  input  control_t    control,
  input  logic [2:0]  funct3,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] mem_data_out,
  output logic        misaligned_out
);
  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef MEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  localparam bit NW = WAIT_STATES == 0;
  localparam logic [2:0] WL = 3'(WAIT_STATES - 1);
  lsu_state_t state, next;
  logic [2:0] cnt;
  logic [AW+1:0] addr_q, cur_addr;
  logic [31:0] data_q, lo_q, cur_data, rdata, wdata, lane;
  mem_size_t size_q, size_in, cur_size;
  logic uns_q, st_q, mis_q, req, st_in, mis_in, idle_req, split, lo_last, hi_last, fin, we;
  logic [7:0] be8;
  logic [63:0] wd64;
  logic [3:0] be;
  logic [AW-1:0] widx, maddr;
  logic unused;
  assign unused = ^alu_res_in[31:AW+2];
  assign req = valid_in & (control.mem_read | control.mem_write);
  assign st_in = control.mem_write;
  assign size_in = to_size(funct3[1:0]);
  assign mis_in = is_misaligned(size_in, alu_res_in[1:0]);
  assign idle_req = state == IDLE && req;
  assign split = SPLIT && mis_q;
  assign lo_last = (state == ACCESS && NW) || (state == WAIT && cnt == WL);
  assign hi_last = (state == ACCESS_HI && NW) || (state == WAIT_HI && cnt == WL);
  assign fin = (lo_last && !split) || hi_last;
  assign stall_out = rst && (idle_req || (state != IDLE && state != DONE));
  assign valid_out = state == DONE;
  // A new access is issued from the live inputs in IDLE, later phases use the latched request
  assign cur_addr = state == IDLE ? alu_res_in[AW+1:0] : addr_q;
  assign cur_data = state == IDLE ? mem_data_in : data_q;
  assign cur_size = state == IDLE ? size_in : size_q;
  assign be8 = {4'b0, size_mask(cur_size)} << cur_addr[1:0];
  assign wd64 = {32'b0, cur_data} << {cur_addr[1:0], 3'b0};
  assign widx = cur_addr[AW+1:2];
  assign maddr = lo_last ? widx + AW'(1) : widx;
  assign we = (idle_req && st_in && (!mis_in || SPLIT)) || (lo_last && split && st_q);
  assign be = lo_last ? be8[7:4] : be8[3:0];
  assign wdata = lo_last ? wd64[63:32] : wd64[31:0];
  assign lane = 32'({rdata, split ? lo_q : rdata} >> {addr_q[1:0], 3'b0});
  data_memory_be #(.DEPTH_WORDS(DEPTH_WORDS), .WAIT_STATES(WAIT_STATES)) u_mem (
    .clk(clk), .we(we), .be(be), .addr(maddr), .wdata(wdata), .rdata(rdata)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = !req ? IDLE : (mis_in && !SPLIT) ? DONE : ACCESS;
      ACCESS:    next = !NW ? WAIT : split ? ACCESS_HI : DONE;
      WAIT:      next = cnt != WL ? WAIT : split ? ACCESS_HI : DONE;
      ACCESS_HI: next = NW ? DONE : WAIT_HI;
      WAIT_HI:   next = cnt != WL ? WAIT_HI : DONE;
      default:   next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      data_q <= '0;
      lo_q <= '0;
      size_q <= MEM_BYTE;
      uns_q <= 1'b0;
      st_q <= 1'b0;
      mis_q <= 1'b0;
      mem_data_out <= '0;
      misaligned_out <= 1'b0;
    end else begin
      state <= next;
      cnt <= (state == WAIT || state == WAIT_HI) ? cnt + 3'd1 : 3'd0;
      if (idle_req) begin
        addr_q <= alu_res_in[AW+1:0];
        data_q <= mem_data_in;
        size_q <= size_in;
        uns_q <= funct3[F3_UNS];
        st_q <= st_in;
        mis_q <= mis_in;
      end
      if (lo_last) lo_q <= rdata;
      if (fin) begin
        mem_data_out <= st_q ? '0 : extend(lane, size_q, uns_q);
        misaligned_out <= mis_q;
      end else if (idle_req && mis_in && !SPLIT) begin
        mem_data_out <= '0;
        misaligned_out <= 1'b1;
      end
    end
  end
endmodule
